// File: rtl/counter_rr_scheduler_if.sv
// rtl/counter_rr_scheduler_if.sv - requester/scheduler bus for the shared interval counter
interface counter_rr_scheduler_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      binary;
  logic [NREQ-1:0]       done;
  logic                  busy;

  modport master (
    output req, len,
    input  grant, binary, done, busy
  );

  modport slave (
    input  req, len,
    output grant, binary, done, busy
  );
endinterface

// File: rtl/counter_rr_scheduler.sv
// rtl/counter_rr_scheduler.sv - round-robin owner of one up-counter timing len+1 tick intervals
// Define CNT_SCHED_FIXED_PRIO_EN for fixed lowest-index-first arbitration instead of round-robin.
module counter_rr_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input logic                   clk,
  input logic                   reset,
  counter_rr_scheduler_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             busy_q, busy_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  // Descending scan so the last hit kept is the highest-priority candidate.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
`ifdef CNT_SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(i);
      end
    end
`else
    for (int off = NREQ; off >= 1; off--) begin
      if (bus.req[(int'(ptr_q) + off) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(ptr_q) + off) % NREQ);
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    binary_d = binary_q;
    len_d    = len_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        grant_d  = '0;
        binary_d = '0;
        busy_d   = 1'b0;
        if (pick_valid) begin
          state_d  = RUN;
          grant_d  = NREQ'(1) << pick_idx;
          busy_d   = 1'b1;
          idx_d    = pick_idx;
          len_d    = bus.len[int'(pick_idx)*WIDTH +: WIDTH];
        end
      end
      RUN: begin
        // A dropped request outranks completion: abort never pulses done.
        if (!bus.req[idx_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          binary_d = '0;
          busy_d   = 1'b0;
          ptr_d    = idx_q;
        end else if (binary_q == len_q) begin
          state_d  = IDLE;
          grant_d  = '0;
          binary_d = '0;
          busy_d   = 1'b0;
          done_d   = NREQ'(1) << idx_q;
          ptr_d    = idx_q;
        end else begin
          binary_d = binary_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      binary_q <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      idx_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      binary_q <= binary_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.binary = binary_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_counter_rr_scheduler.sv
// tb/tb_counter_rr_scheduler.sv - directed vector bench for counter_rr_scheduler
module tb_counter_rr_scheduler;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  counter_rr_scheduler_if #(.WIDTH(4), .NREQ(4)) bus ();

  counter_rr_scheduler #(.WIDTH(4), .NREQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [3:0]  d;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [15:0] len,
                              input logic [3:0] g, input logic [3:0] b, input logic [3:0] d,
                              input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.len = len; v.g = g; v.b = b; v.d = d; v.busy = busy;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] g, input logic [3:0] b,
                       input logic [3:0] d, input logic bz);
    checks++;
    if (bus.grant !== g || bus.binary !== b || bus.done !== d || bus.busy !== bz) begin
      errors++;
      $display("FAIL %s: got grant=%b binary=%0d done=%b busy=%b, expected grant=%b binary=%0d done=%b busy=%b",
               nm, bus.grant, bus.binary, bus.done, bus.busy, g, b, d, bz);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.req = '0;
    bus.len = '0;
    step();
    step();
    check("reset_state", 4'b0000, 4'd0, 4'b0000, 1'b0);
    reset = 1'b0;

    // single request, len0=3
    tbl.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 4'd0, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 4'd1, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 4'd2, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0001, 16'h0003, 4'b0001, 4'd3, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0001, 16'h0003, 4'b0000, 4'd0, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0003, 4'b0000, 4'd0, 4'b0000, 0));
    // round-robin from reset, all len=1
    tbl.push_back(mk(1, 4'b0000, 16'h1111, 4'b0000, 4'd0, 4'b0000, 0));
    for (int r = 0; r < 4; r++) begin
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 4'(1 << r), 4'd0, 4'b0000, 1));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 4'(1 << r), 4'd1, 4'b0000, 1));
      tbl.push_back(mk(0, 4'b1111, 16'h1111, 4'b0000, 4'd0, 4'(1 << r), 0));
    end
    tbl.push_back(mk(0, 4'b1111, 16'h1111, 4'b0001, 4'd0, 4'b0000, 1));

    foreach (tbl[i]) begin
      reset   = tbl[i].rst;
      bus.req = tbl[i].req;
      bus.len = tbl[i].len;
      step();
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].b, tbl[i].d, tbl[i].busy);
    end

    // len=0 from reset
    reset = 1'b1; bus.req = '0; bus.len = 16'h0000;
    step();
    reset = 1'b0; bus.req = 4'b0001;
    step();
    check("len0_run", 4'b0001, 4'd0, 4'b0000, 1'b1);
    step();
    check("len0_done", 4'b0000, 4'd0, 4'b0001, 1'b0);
    bus.req = '0;
    step();
    check("len0_idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

    // len=15 on requester 1: full count without wrap
    bus.req = 4'b0010; bus.len = 16'h00F0;
    step();
    check("len15_start", 4'b0010, 4'd0, 4'b0000, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("len15_b%0d", k), 4'b0010, 4'(k), 4'b0000, 1'b1);
    end
    step();
    check("len15_done", 4'b0000, 4'd0, 4'b0010, 1'b0);
    bus.req = '0;
    step();

    // abort requester 2 at binary=4, then 0101 grants requester 0
    bus.req = 4'b0100; bus.len = 16'h0A05;
    step();
    check("abort_start", 4'b0100, 4'd0, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) step();
    check("abort_b4", 4'b0100, 4'd4, 4'b0000, 1'b1);
    bus.req = '0;
    step();
    check("abort_idle", 4'b0000, 4'd0, 4'b0000, 1'b0);
    bus.req = 4'b0101;
    step();
    check("abort_rr_wrap", 4'b0001, 4'd0, 4'b0000, 1'b1);
    bus.req = '0;
    step();
    check("abort2_idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

    // reset mid-RUN at binary=5; ptr returns to NREQ-1 so requester 0 wins next
    bus.req = 4'b0011; bus.len = 16'h0077;
    step();
    check("rst_run_start", 4'b0010, 4'd0, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) step();
    check("rst_run_b5", 4'b0010, 4'd5, 4'b0000, 1'b1);
    reset = 1'b1; bus.len = 16'h0073;
    step();
    check("rst_mid_run", 4'b0000, 4'd0, 4'b0000, 1'b0);
    reset = 1'b0;
    step();
    check("rst_first_grant", 4'b0001, 4'd0, 4'b0000, 1'b1);

    // len0 changed 3->9 at binary=1 is ignored
    step();
    check("lenchg_b1", 4'b0001, 4'd1, 4'b0000, 1'b1);
    bus.len = 16'h0079;
    step();
    check("lenchg_b2", 4'b0001, 4'd2, 4'b0000, 1'b1);
    step();
    check("lenchg_b3", 4'b0001, 4'd3, 4'b0000, 1'b1);
    step();
    check("lenchg_done", 4'b0000, 4'd0, 4'b0001, 1'b0);
    step();
    check("lenchg_next_rr", 4'b0010, 4'd0, 4'b0000, 1'b1);
    bus.req = '0;
    step();
    check("final_idle", 4'b0000, 4'd0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
